bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single RAM port between the two cores' caches: four requesters, icache0, dcache0, icache1 and dcache1.
- Sits between the per-core cache blocks and the RAM model/memory controller.
- Arbitrates fairly between cores (round-robin) and strictly within a core (dcache before icache).
- Holds each grant until RAM completes, then returns data or ack to the winner via its wait line.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  2  icache read request; bit c = core c.
- iaddr  in  2*ADDR_W  icache address; slice c = core c.
- iwait  out  2  icache wait; low for exactly one cycle when the read completes.
- iload  out  2*DATA_W  icache read data; valid only while the matching iwait is low.
- dREN  in  2  dcache read request.
- dWEN  in  2  dcache write request.
- daddr  in  2*ADDR_W  dcache address.
- dstore  in  2*DATA_W  dcache write data.
- dwait  out  2  dcache wait; low for exactly one cycle on completion.
- dload  out  2*DATA_W  dcache read data; valid only while the matching dwait is low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM completes the current access this cycle.

Behaviour:
- Clock/reset: one clock CLK; reset nRST is synchronous, active-low. All state updates on the CLK rising edge.
- Reset values:
  - state=IDLE, grant=none, last_core=1, so core 0 wins first.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=2'b11, dwait=2'b11.
- Requester active:
  - dcache c is active when dREN[c] or dWEN[c] is high.
  - If dREN[c] and dWEN[c] are both high, the access is a write.
  - icache c is active when iREN[c] is high.
- States: IDLE and BUSY.
- IDLE:
  - If any requester is active, latch grant = {core, d/i, rd/wr} and go to BUSY.
  - Core order: the core other than last_core first, then last_core.
  - Within a core: dcache first, then icache.
  - With no requester active, stay in IDLE.
  - All RAM strobes are 0 and all waits are 1 in IDLE.
- BUSY:
  - ramREN or ramWEN is driven per the latched grant.
  - ramaddr and ramstore are muxed combinationally from the granted requester's live inputs.
  - If ram_ready=1 and the granted request is still asserted:
    - the granted wait goes low this cycle;
    - iload/dload slice for that core = ramload;
    - last_core <= granted core;
    - next state = IDLE.
  - If the granted request drops before ram_ready (abort):
    - strobes go 0 immediately;
    - no wait pulse;
    - next state = IDLE;
    - last_core is unchanged.
  - Otherwise stay in BUSY.
- Latency and throughput:
  - Request first seen at cycle N gives strobes at N+1.
  - Minimum completion is at N+1, when ram_ready is already high.
  - The IDLE bubble between grants is mandatory: at most one completion every 2 cycles.
- Grant latching:
  - The grant is never changed while in BUSY, even if a higher-priority request arrives.
  - A non-granted requester's wait stays 1 throughout.
- Completion pulse:
  - Only one of the four wait bits is ever low in a cycle.
  - The requester must drop or change its request the cycle after its wait goes low. If it is still asserted, it is treated as a new request in IDLE.
- Unselected iload/dload slices are don't-care. Drive them to ramload for simplicity.
- Reset mid-operation:
  - nRST low at any edge returns all state to reset values, including last_core=1.
  - Strobes are 0 the next cycle.
  - In-flight access is dropped without a wait pulse.
- Outputs are glitch-free with respect to the state register. RAM strobes are decoded from state plus grant only, never from raw requests, except for the abort kill.

Test Plan:
- Single read: iREN=2'b01, iaddr0=0x100, ram_ready high after 3 BUSY cycles, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 for 3 cycles, iwait[0] low one cycle with iload0=0xDEADBEEF, then IDLE.
- Intra-core priority: dREN[0] and iREN[0] together, ram_ready=1 always -> dcache0 served first (dwait[0] pulse), icache0 two cycles later.
- Round-robin: all four requesters held, ram_ready=1 -> service order d0, d1, i0, i1. Each completion is one cycle of wait low followed by an IDLE bubble.
- Write: dWEN[1]=1, dREN[1]=1, daddr1=0x200, dstore1=0x12345678 -> ramWEN=1, ramREN=0, ramaddr=0x200, ramstore=0x12345678, dwait[1] pulse on ram_ready.
- Abort: grant i1, drop iREN[1] before ram_ready -> strobes 0 that cycle, no iwait pulse; last_core is unchanged, so core 0 is still preferred.
- Reset mid-BUSY: nRST=0 for one edge while ramREN=1 -> next cycle ramREN=0, all waits 1, first grant afterwards goes to core 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shares one RAM port between two cores' icache/dcache requesters.
// Cores alternate round-robin; within a core the dcache wins over the icache.
module bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [1:0]          iREN,
    input  logic [2*ADDR_W-1:0] iaddr,
    output logic [1:0]          iwait,
    output logic [2*DATA_W-1:0] iload,
    input  logic [1:0]          dREN,
    input  logic [1:0]          dWEN,
    input  logic [2*ADDR_W-1:0] daddr,
    input  logic [2*DATA_W-1:0] dstore,
    output logic [1:0]          dwait,
    output logic [2*DATA_W-1:0] dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [ADDR_W-1:0]   ramaddr,
    output logic [DATA_W-1:0]   ramstore,
    input  logic [DATA_W-1:0]   ramload,
    input  logic                ram_ready
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e state_q, state_d;
    logic   core_q, core_d;
    logic   is_d_q, is_d_d;
    logic   is_wr_q, is_wr_d;
    logic   last_q, last_d;

    logic [1:0] d_act;
    logic       pri_core;
    logic       live;

    assign d_act = dREN | dWEN;
    assign iload = {2{ramload}};
    assign dload = {2{ramload}};

    always_comb begin
        state_d  = state_q;
        core_d   = core_q;
        is_d_d   = is_d_q;
        is_wr_d  = is_wr_q;
        last_d   = last_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        pri_core = ~last_q;
        live     = is_d_q ? d_act[core_q] : iREN[core_q];

        unique case (state_q)
            StIdle: begin
                if (d_act[pri_core] || iREN[pri_core]) begin
                    state_d = StBusy;
                    core_d  = pri_core;
                    is_d_d  = d_act[pri_core];
                    is_wr_d = d_act[pri_core] & dWEN[pri_core];
                end else if (d_act[last_q] || iREN[last_q]) begin
                    state_d = StBusy;
                    core_d  = last_q;
                    is_d_d  = d_act[last_q];
                    is_wr_d = d_act[last_q] & dWEN[last_q];
                end
            end
            StBusy: begin
                if (is_d_q) begin
                    ramaddr  = core_q ? daddr[2*ADDR_W-1:ADDR_W] : daddr[ADDR_W-1:0];
                    ramstore = core_q ? dstore[2*DATA_W-1:DATA_W] : dstore[DATA_W-1:0];
                end else begin
                    ramaddr  = core_q ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
                end
                // A dropped request kills the strobes at once and abandons the grant.
                if (!live) begin
                    state_d = StIdle;
                end else begin
                    ramREN = ~is_wr_q;
                    ramWEN = is_wr_q;
                    if (ram_ready) begin
                        if (is_d_q) dwait[core_q] = 1'b0;
                        else        iwait[core_q] = 1'b0;
                        last_d  = core_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            core_q  <= 1'b0;
            is_d_q  <= 1'b0;
            is_wr_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            is_d_q  <= is_d_d;
            is_wr_q <= is_wr_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a requester-level model.
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [1:0]    iREN, dREN, dWEN;
    logic [2*AW-1:0] iaddr, daddr;
    logic [2*DW-1:0] dstore;
    logic [1:0]    iwait, dwait;
    logic [2*DW-1:0] iload, dload;
    logic          ramREN, ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore, ramload;
    logic          ram_ready;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Model: requester id r = 2*core + (0 for dcache, 1 for icache); -1 = no owner.
    int   m_owner = -1;
    logic m_wr    = 1'b0;
    int   m_last  = 1;

    function automatic logic req_active(input int r);
        int c;
        c = r / 2;
        if (r % 2 == 0) return dREN[c] | dWEN[c];
        return iREN[c];
    endfunction

    function automatic int pick();
        int c;
        for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? 1 - m_last : m_last;
            if (req_active(2 * c)) return 2 * c;
            if (req_active(2 * c + 1)) return 2 * c + 1;
        end
        return -1;
    endfunction

    always @(posedge CLK) begin : model_update
        int p;
        if (!nRST) begin
            m_owner <= -1;
            m_last  <= 1;
        end else if (m_owner < 0) begin
            p = pick();
            m_owner <= p;
            if (p >= 0) m_wr <= (p % 2 == 0) && dWEN[p / 2];
        end else if (!req_active(m_owner)) begin
            m_owner <= -1;
        end else if (ram_ready) begin
            m_owner <= -1;
            m_last  <= m_owner / 2;
        end
    end

    always @(negedge CLK) begin : compare
        logic          e_ren, e_wen;
        logic [1:0]    e_iw, e_dw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store;
        int            c;
        if (chk_en) begin
            e_ren = 1'b0; e_wen = 1'b0; e_iw = 2'b11; e_dw = 2'b11;
            e_addr = '0; e_store = '0;
            if (m_owner >= 0 && req_active(m_owner)) begin
                c = m_owner / 2;
                e_ren = !m_wr;
                e_wen = m_wr;
                if (m_owner % 2 == 0) begin
                    e_addr  = daddr[c*AW +: AW];
                    e_store = dstore[c*DW +: DW];
                    if (ram_ready) e_dw[c] = 1'b0;
                end else begin
                    e_addr = iaddr[c*AW +: AW];
                    if (ram_ready) e_iw[c] = 1'b0;
                end
            end
            check("ramREN", ramREN, e_ren);
            check("ramWEN", ramWEN, e_wen);
            check("iwait", iwait, e_iw);
            check("dwait", dwait, e_dw);
            if (e_ren || e_wen) begin
                check("ramaddr", ramaddr, e_addr);
                check("ramstore", ramstore, e_store);
            end
            if (m_owner < 0) begin
                check("idle_ramaddr", ramaddr, 0);
                check("idle_ramstore", ramstore, 0);
            end
            for (int k = 0; k < 2; k++) begin
                if (!e_iw[k]) check("iload", iload[k*DW +: DW], ramload);
                if (!e_dw[k]) check("dload", dload[k*DW +: DW], ramload);
            end
        end
    end

    int   rr_order[4];
    int   rr_cyc[4];
    int   exp_order[4] = '{0, 2, 1, 3};
    int   n, cyc, who;

    initial begin
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);
        check("reset_iwait", iwait, 2'b11);
        check("reset_dwait", dwait, 2'b11);
        check("reset_ramREN", ramREN, 1'b0);
        check("reset_ramaddr", ramaddr, 0);

        // Single icache0 read, RAM ready on the third busy cycle.
        tick();
        iREN = 2'b01; iaddr[31:0] = 32'h100; ramload = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) ram_ready = 1'b1;
            @(negedge CLK);
            check("rd_ramREN", ramREN, 1'b1);
            check("rd_ramaddr", ramaddr, 32'h100);
            check("rd_iwait", iwait, (k == 2) ? 2'b10 : 2'b11);
        end
        check("rd_iload", iload[31:0], 32'hDEADBEEF);
        tick();
        iREN = 2'b00; ram_ready = 1'b0;
        @(negedge CLK);
        check("rd_idle_ramREN", ramREN, 1'b0);

        // dcache1 write with both strobes requested.
        tick();
        dREN = 2'b10; dWEN = 2'b10; daddr[63:32] = 32'h200; dstore[63:32] = 32'h12345678;
        ram_ready = 1'b1;
        tick();
        @(negedge CLK);
        check("wr_ramWEN", ramWEN, 1'b1);
        check("wr_ramREN", ramREN, 1'b0);
        check("wr_ramaddr", ramaddr, 32'h200);
        check("wr_ramstore", ramstore, 32'h12345678);
        check("wr_dwait", dwait, 2'b01);
        tick();
        dREN = 2'b00; dWEN = 2'b00;

        // Intra-core priority on core 0.
        tick();
        dREN = 2'b01; iREN = 2'b01; daddr[31:0] = 32'h440; iaddr[31:0] = 32'h880;
        tick();
        @(negedge CLK);
        check("pri_dwait", dwait, 2'b10);
        check("pri_iwait_held", iwait, 2'b11);
        tick();
        dREN = 2'b00;
        @(negedge CLK);
        check("pri_bubble", {iwait, dwait}, 4'b1111);
        tick();
        @(negedge CLK);
        check("pri_iwait", iwait, 2'b10);
        tick();
        iREN = 2'b00;

        // Round-robin with all four held, starting from reset.
        nRST = 1'b0;
        tick();
        nRST = 1'b1; dREN = 2'b11; iREN = 2'b11; dWEN = 2'b00; ram_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 20) begin
            @(negedge CLK);
            who = -1;
            if (!dwait[0]) who = 0;
            else if (!dwait[1]) who = 2;
            else if (!iwait[0]) who = 1;
            else if (!iwait[1]) who = 3;
            if (who >= 0) begin
                rr_order[n] = who;
                rr_cyc[n] = cyc;
                n++;
            end
            tick();
            cyc++;
            case (who)
                0: dREN[0] = 1'b0;
                1: iREN[0] = 1'b0;
                2: dREN[1] = 1'b0;
                3: iREN[1] = 1'b0;
                default: ;
            endcase
        end
        check("rr_count", n, 4);
        for (int k = 0; k < n; k++) begin
            check("rr_order", rr_order[k], exp_order[k]);
            if (k > 0) check("rr_spacing", rr_cyc[k] - rr_cyc[k-1], 2);
        end
        dREN = 2'b00; iREN = 2'b00;

        // Abort of an icache1 grant leaves core 0 preferred.
        tick();
        iREN = 2'b10; iaddr[63:32] = 32'h700; ram_ready = 1'b0;
        tick();
        @(negedge CLK);
        check("ab_ramREN_busy", ramREN, 1'b1);
        tick();
        iREN = 2'b00;
        @(negedge CLK);
        check("ab_ramREN_kill", ramREN, 1'b0);
        check("ab_iwait", iwait, 2'b11);
        tick();
        dREN = 2'b11; ram_ready = 1'b1;
        tick();
        @(negedge CLK);
        check("ab_core0_first", dwait, 2'b10);
        tick();
        dREN = 2'b00; ram_ready = 1'b0;

        // Reset while busy.
        tick();
        iREN = 2'b10;
        tick();
        @(negedge CLK);
        check("rst_busy_ramREN", ramREN, 1'b1);
        tick();
        nRST = 1'b0;
        tick();
        nRST = 1'b1; iREN = 2'b11; iaddr = {32'h400, 32'h300};
        @(negedge CLK);
        check("rst_ramREN", ramREN, 1'b0);
        check("rst_waits", {iwait, dwait}, 4'b1111);
        tick();
        @(negedge CLK);
        check("rst_core0_addr", ramaddr, 32'h300);
        tick();
        iREN = 2'b00;

        // Randomized traffic.
        for (int t = 0; t < 4000; t++) begin
            tick();
            nRST = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) iREN[k] = ~iREN[k];
                if ($urandom_range(0, 3) == 0) dREN[k] = ~dREN[k];
                if ($urandom_range(0, 5) == 0) dWEN[k] = ~dWEN[k];
            end
            iaddr = {$urandom, $urandom};
            daddr = {$urandom, $urandom};
            dstore = {$urandom, $urandom};
            ramload = $urandom;
            ram_ready = $urandom_range(0, 1) == 1;
        end
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
